// File: rtl/speech_pkg.sv
// Shared constants for the speech word player: defaults, FSM encoding and
// the word indices used by the calculator controller firmware.
package speech_pkg;

  localparam int unsigned DEF_ADDR_W    = 23;
  localparam int unsigned DEF_NUM_WORDS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_WAIT,
    ST_PLAY_LO,
    ST_PLAY_HI,
    ST_DONE
  } state_t;

  localparam logic [7:0] W_DIGIT_0 = 8'h00;
  localparam logic [7:0] W_DIGIT_1 = 8'h01;
  localparam logic [7:0] W_DIGIT_2 = 8'h02;
  localparam logic [7:0] W_DIGIT_3 = 8'h03;
  localparam logic [7:0] W_DIGIT_4 = 8'h04;
  localparam logic [7:0] W_DIGIT_5 = 8'h05;
  localparam logic [7:0] W_DIGIT_6 = 8'h06;
  localparam logic [7:0] W_DIGIT_7 = 8'h07;
  localparam logic [7:0] W_DIGIT_8 = 8'h08;
  localparam logic [7:0] W_DIGIT_9 = 8'h09;
  localparam logic [7:0] W_PLUS    = 8'h0A;
  localparam logic [7:0] W_MINUS   = 8'h0B;
  localparam logic [7:0] W_EQUALS  = 8'h0C;
  localparam logic [7:0] W_TIMES   = 8'h0D;
  localparam logic [7:0] W_DIVIDE  = 8'h0E;
  localparam logic [7:0] W_POINT   = 8'h0F;
  localparam logic [7:0] W_CLEAR   = 8'h10;

endpackage

// File: rtl/speech_word_rom.sv
// Word index to inclusive flash word-address range. Unlisted indices
// return end < start, which the player treats as an empty word.
module speech_word_rom
  import speech_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [7:0]        idx,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr
);

  always_comb begin
    start_addr = ADDR_W'(1);
    end_addr   = '0;
    case (idx)
      W_DIGIT_0: begin start_addr = ADDR_W'(32'h000000); end_addr = ADDR_W'(32'h00007F); end
      W_DIGIT_1: begin start_addr = ADDR_W'(32'h000080); end_addr = ADDR_W'(32'h0000FF); end
      W_DIGIT_2: begin start_addr = ADDR_W'(32'h000180); end_addr = ADDR_W'(32'h0001FF); end
      W_DIGIT_3: begin start_addr = ADDR_W'(32'h000100); end_addr = ADDR_W'(32'h000101); end
      W_DIGIT_4: begin start_addr = ADDR_W'(32'h000200); end_addr = ADDR_W'(32'h00027F); end
      W_DIGIT_5: begin start_addr = ADDR_W'(32'h000280); end_addr = ADDR_W'(32'h0002FF); end
      W_DIGIT_6: begin start_addr = ADDR_W'(32'h000300); end_addr = ADDR_W'(32'h00037F); end
      W_DIGIT_7: begin start_addr = ADDR_W'(32'h000380); end_addr = ADDR_W'(32'h0003FF); end
      W_DIGIT_8: begin start_addr = ADDR_W'(32'h000400); end_addr = ADDR_W'(32'h00047F); end
      W_DIGIT_9: begin start_addr = ADDR_W'(32'h000480); end_addr = ADDR_W'(32'h0004FF); end
      W_PLUS:    begin start_addr = ADDR_W'(32'h000500); end_addr = ADDR_W'(32'h00053F); end
      W_MINUS:   begin start_addr = ADDR_W'(32'h000540); end_addr = ADDR_W'(32'h00057F); end
      W_EQUALS:  begin start_addr = ADDR_W'(32'h000580); end_addr = ADDR_W'(32'h0005BF); end
      W_TIMES:   begin start_addr = ADDR_W'(32'h0005C0); end_addr = ADDR_W'(32'h0005FF); end
      W_DIVIDE:  begin start_addr = ADDR_W'(32'h000600); end_addr = ADDR_W'(32'h00063F); end
      W_POINT:   begin start_addr = ADDR_W'(32'h000640); end_addr = ADDR_W'(32'h00067F); end
      W_CLEAR:   begin start_addr = ADDR_W'(32'h000680); end_addr = ADDR_W'(32'h0006FF); end
      default:   begin start_addr = ADDR_W'(1);         end_addr = '0;                   end
    endcase
  end

endmodule

// File: rtl/speech_word_player.sv
// Plays one speech word: looks up its flash range, fetches 32-bit words one
// at a time and emits two 16-bit samples per word on the sample-rate tick.
module speech_word_player
  import speech_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 25000000,
  parameter int unsigned SAMPLE_RATE_HZ = 22000,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned NUM_WORDS      = DEF_NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        word_sel,
  input  logic              play,
  input  logic              stop,
  output logic              busy,
  output logic              word_done,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_read,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [15:0]       sample_out,
  output logic              sample_valid
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [7:0]        idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rom_start;
  logic [ADDR_W-1:0] rom_end;
  logic [31:0]       data_buf;
  logic              stop_pend;
  logic              orphan;
  logic              empty_word;

  speech_word_rom #(.ADDR_W(ADDR_W)) u_rom (
    .idx        (idx),
    .start_addr (rom_start),
    .end_addr   (rom_end)
  );

  assign tick       = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign empty_word = (32'(idx) >= NUM_WORDS) || (rom_end < rom_start);

  // orphan marks an accepted read abandoned by stop; its data is discarded and
  // no new request is raised until it has drained.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      idx          <= '0;
      cur_addr     <= '0;
      data_buf     <= '0;
      stop_pend    <= 1'b0;
      orphan       <= 1'b0;
      busy         <= 1'b0;
      word_done    <= 1'b0;
      flash_addr   <= '0;
      flash_read   <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      word_done    <= 1'b0;
      if (state == ST_IDLE) tick_cnt <= '0;
      else                  tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (flash_readdatavalid) orphan <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (play) begin
            idx       <= word_sel;
            busy      <= 1'b1;
            stop_pend <= 1'b0;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (stop || empty_word) begin
            state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
          end else begin
            cur_addr   <= rom_start;
            flash_addr <= rom_start;
            flash_read <= !orphan || flash_readdatavalid;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flash_read) begin
            if (stop) stop_pend <= 1'b1;
            if (!flash_waitrequest) begin
              flash_read <= 1'b0;
              if (stop || stop_pend) begin
                orphan <= 1'b1;
                state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
              end else begin
                state <= ST_WAIT;
              end
            end
          end else if (stop || stop_pend) begin
            state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
          end else if (!orphan || flash_readdatavalid) begin
            flash_read <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (flash_readdatavalid) begin
            data_buf <= flash_readdata;
            if (stop) begin
              state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
            end else begin
              state <= ST_PLAY_LO;
            end
          end else if (stop) begin
            orphan <= 1'b1;
            state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
          end
        end
        ST_PLAY_LO: begin
          if (stop) begin
            state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
          end else if (tick) begin
            sample_out   <= data_buf[15:0];
            sample_valid <= 1'b1;
            state        <= ST_PLAY_HI;
          end
        end
        ST_PLAY_HI: begin
          if (stop) begin
            state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
          end else if (tick) begin
            sample_out   <= data_buf[31:16];
            sample_valid <= 1'b1;
            if (cur_addr == rom_end) begin
              state <= ST_DONE; word_done <= 1'b1; busy <= 1'b0;
            end else begin
              cur_addr   <= cur_addr + ADDR_W'(1);
              flash_addr <= cur_addr + ADDR_W'(1);
              flash_read <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speech_word_player.sv
// Scoreboard bench for speech_word_player with a small Avalon-style flash
// model that supports programmable waitrequest stalls and read latency.
module tb_speech_word_player;
  import speech_pkg::*;

  localparam int unsigned TICK = 1136;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  word_sel;
  logic        play;
  logic        stop;
  logic        busy;
  logic        word_done;
  logic [22:0] flash_addr;
  logic        flash_read;
  logic        flash_waitrequest;
  logic        flash_readdatavalid;
  logic [31:0] flash_readdata;
  logic [15:0] sample_out;
  logic        sample_valid;

  always #5 clk = ~clk;

  speech_word_player dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .word_sel            (word_sel),
    .play                (play),
    .stop                (stop),
    .busy                (busy),
    .word_done           (word_done),
    .flash_addr          (flash_addr),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .sample_out          (sample_out),
    .sample_valid        (sample_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  int cyc = 0;
  int play_cyc = 0, last_smp_cyc = 0, done_cyc = 0, done_cnt = 0;
  bit first_smp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every sample and checks timing
  initial forever begin
    @(negedge clk);
    if (sample_valid) begin
      check("sample_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sample_value", 32'(sample_out), 32'(exp_q.pop_front()));
      if (first_smp) check("first_sample_latency", 32'(cyc - play_cyc), 32'd1137);
      else           check("sample_spacing", 32'(cyc - last_smp_cyc), 32'(TICK));
      first_smp    = 1'b0;
      last_smp_cyc = cyc;
    end
    if (word_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_clear_at_done", 32'(busy), 32'd0);
    end
  end

  // Flash model
  int ws_cfg = 0, lat_cfg = 2, stall_cycles = 0, accepts = 0;
  bit saw_read = 1'b0, req_unstable = 1'b0;

  function automatic logic [31:0] flash_mem(input logic [22:0] a);
    case (a)
      23'h000100: return 32'h22221111;
      23'h000101: return 32'h44443333;
      default:    return {9'h1AD, a};
    endcase
  endfunction

  initial begin
    bit          in_req;
    logic [22:0] req_addr;
    int          ws_left, lat_left;
    logic [31:0] pend;
    in_req = 1'b0; req_addr = '0; ws_left = 0; lat_left = 0; pend = '0;
    flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0; flash_readdata = '0;
    forever begin
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata      = pend;
        end
      end
      if (flash_read) begin
        saw_read = 1'b1;
        if (!in_req) begin
          in_req = 1'b1; req_addr = flash_addr; ws_left = ws_cfg;
        end else if (flash_addr !== req_addr) begin
          req_unstable = 1'b1;
        end
        if (ws_left > 0) begin
          flash_waitrequest = 1'b1; ws_left--; stall_cycles++;
        end else begin
          flash_waitrequest = 1'b0; in_req = 1'b0;
          pend = flash_mem(req_addr); lat_left = lat_cfg; accepts++;
        end
      end else begin
        if (in_req) req_unstable = 1'b1;
        in_req = 1'b0;
        flash_waitrequest = 1'b0;
      end
    end
  end

  task automatic do_play(input logic [7:0] sel, input logic with_stop);
    @(negedge clk);
    word_sel = sel; play = 1'b1; stop = with_stop;
    play_cyc = cyc; first_smp = 1'b1;
    @(negedge clk);
    play = 1'b0; stop = 1'b0;
    check("busy_after_play", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = word_done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(word_done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_word_done"}, 32'(word_done), 32'd0);
    check({tag, "_flash_read"}, 32'(flash_read), 32'd0);
    check({tag, "_flash_addr"}, 32'(flash_addr), 32'd0);
    check({tag, "_sample_out"}, 32'(sample_out), 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
  endtask

  task automatic push_word3();
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
  endtask

  initial begin
    int d0;
    reset_n = 1'b0; word_sel = '0; play = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic word, no stalls, 2-cycle latency
    push_word3();
    do_play(W_DIGIT_3, 1'b0);
    wait_done("basic", 6000);
    check("basic_done_with_last_sample", 32'(done_cyc - last_smp_cyc), 32'd0);
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same word with 5-cycle waitrequest on each request
    ws_cfg = 5; stall_cycles = 0; req_unstable = 1'b0;
    push_word3();
    do_play(W_DIGIT_3, 1'b0);
    wait_done("stall", 6000);
    check("stall_cycles", 32'(stall_cycles), 32'd10);
    check("stall_req_stable", 32'(req_unstable), 32'd0);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    ws_cfg = 0;

    // Out-of-range word, with stop alongside play in IDLE
    saw_read = 1'b0;
    do_play(8'hFF, 1'b1);
    wait_done("empty", 20);
    check("empty_done_latency", 32'(done_cyc - play_cyc), 32'd2);
    check("empty_no_flash_read", 32'(saw_read), 32'd0);

    // Second play while busy is ignored
    d0 = done_cnt;
    push_word3();
    do_play(W_DIGIT_3, 1'b0);
    repeat (8) @(negedge clk);
    word_sel = W_DIGIT_5; play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    wait_done("replay", 6000);
    repeat (20) @(negedge clk);
    check("replay_one_done", 32'(done_cnt - d0), 32'd1);
    check("replay_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stop while waiting on the second flash word; its data arrives late
    lat_cfg = 40; accepts = 0; d0 = done_cnt;
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    do_play(W_DIGIT_3, 1'b0);
    for (int i = 0; i < 3000 && accepts < 2; i++) @(negedge clk);
    check("stop_second_accept", 32'(accepts), 32'd2);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_done_pulse", 32'(word_done), 32'd1);
    repeat (1500) @(negedge clk);
    check("stop_one_done", 32'(done_cnt - d0), 32'd1);
    check("stop_queue_empty", 32'(exp_q.size()), 32'd0);
    lat_cfg = 2;
    push_word3();
    do_play(W_DIGIT_3, 1'b0);
    wait_done("after_stop", 6000);
    check("after_stop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset pulse during PLAY_HI
    push_word3();
    do_play(W_DIGIT_3, 1'b0);
    for (int i = 0; i < 2000 && exp_q.size() != 3; i++) @(negedge clk);
    check("rst_first_sample_seen", 32'(exp_q.size()), 32'd3);
    repeat (100) @(negedge clk);
    d0 = done_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    check_cleared("midrst");
    reset_n = 1'b1;
    exp_q.delete();
    repeat (1500) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    push_word3();
    do_play(W_DIGIT_3, 1'b0);
    wait_done("after_rst", 6000);
    check("after_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
